// File: rtl/axi_pkg.sv
// Shared types and constants for the IF/MEM AXI master arbiter.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_DONE
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DMEM   = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin winner; the caller owns the last pointer.
module rr_arbiter2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,   // 1 = dmem was granted last
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt = '0;
    case (req)
      2'b01: gnt[REQ_IFETCH] = 1'b1;
      2'b10: gnt[REQ_DMEM]   = 1'b1;
      2'b11: begin
        if (last) gnt[REQ_IFETCH] = 1'b1;
        else      gnt[REQ_DMEM]   = 1'b1;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 master between ifetch and dmem: one outstanding transaction,
// round-robin grant, AR/R and AW/W/B sequencing from latched request fields.
module axi_mem_arbiter
  import axi_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [1:0]            req,
  input  logic [1:0]            rw,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [2*STRB_W-1:0]   wstrb,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [1:0]            gnt,

  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [STRB_W-1:0]     m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  arb_state_t          state, state_nxt;
  logic [1:0]          win_gnt;
  logic                win_idx;
  logic                win_rw;
  logic [1:0]          gnt_q;
  logic                last_q;
  logic                aw_ok, w_ok;
  logic [1:0]          resp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_wdata;
  logic [STRB_W-1:0]   hold_wstrb;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (win_gnt)
  );

  assign win_idx = win_gnt[REQ_DMEM];
  assign win_rw  = win_idx ? rw[REQ_DMEM] : rw[REQ_IFETCH];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (|req) state_nxt = win_rw ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      ST_RD_ADDR:      if (m_axi_arready) state_nxt = ST_RD_DATA;
      ST_RD_DATA:      if (m_axi_rvalid) state_nxt = ST_DONE;
      ST_WR_ADDR_DATA: if ((aw_ok || m_axi_awready) && (w_ok || m_axi_wready))
                         state_nxt = ST_WR_RESP;
      ST_WR_RESP:      if (m_axi_bvalid) state_nxt = ST_DONE;
      ST_DONE:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registered flags only.
  always_comb begin
    m_axi_arvalid = (state == ST_RD_ADDR);
    m_axi_rready  = (state == ST_RD_DATA);
    m_axi_awvalid = (state == ST_WR_ADDR_DATA) && !aw_ok;
    m_axi_wvalid  = (state == ST_WR_ADDR_DATA) && !w_ok;
    m_axi_bready  = (state == ST_WR_RESP);
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE) ? gnt_q : 2'b00;
    err           = done & {2{resp_q != AXI_RESP_OKAY}};
  end

  assign gnt          = gnt_q;
  assign rdata        = rdata_q;
  assign m_axi_araddr = hold_addr;
  assign m_axi_awaddr = hold_addr;
  assign m_axi_wdata  = hold_wdata;
  assign m_axi_wstrb  = hold_wstrb;

  // Control registers: grant, round-robin pointer, handshake flags, response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      last_q  <= 1'b1;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      resp_q  <= AXI_RESP_OKAY;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          aw_ok <= 1'b0;
          w_ok  <= 1'b0;
          if (|req) gnt_q <= win_gnt;
        end
        ST_WR_ADDR_DATA: begin
          if (m_axi_awready) aw_ok <= 1'b1;
          if (m_axi_wready)  w_ok  <= 1'b1;
        end
        ST_RD_DATA: if (m_axi_rvalid) begin
          rdata_q <= m_axi_rdata;
          resp_q  <= m_axi_rresp;
        end
        ST_WR_RESP: if (m_axi_bvalid) resp_q <= m_axi_bresp;
        ST_DONE: begin
          last_q <= gnt_q[REQ_DMEM];
          gnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Request holding registers, loaded only when a grant is issued.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are only observed while a valid they qualify is high.
    if (state == ST_IDLE && |req) begin
      hold_addr  <= win_idx ? addr[ADDR_W +: ADDR_W]   : addr[0 +: ADDR_W];
      hold_wdata <= win_idx ? wdata[DATA_W +: DATA_W]  : wdata[0 +: DATA_W];
      hold_wstrb <= win_idx ? wstrb[STRB_W +: STRB_W]  : wstrb[0 +: STRB_W];
    end
  end

endmodule
